// File: rtl/axi_bus_pkg.sv
// Shared definitions for the master_logic / slave_logic byte link:
// default data width, FSM state encoding and the transfer-counter width.
package axi_bus_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 4;
  localparam int TXCNT_W        = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Width of a counter that must represent 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : axi_bus_pkg

// File: rtl/master_logic_if.sv
// Valid/ready byte link between master_logic (producer) and slave_logic (consumer).
interface master_logic_if
  import axi_bus_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              s_ready;

  modport master (
    output m_valid,
    output m_data,
    input  s_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output s_ready
  );

endinterface : master_logic_if

// File: rtl/master_logic_byte_fifo.sv
// byte_fifo: DEPTH-entry FIFO with a separate occupancy count so full and
// empty are never ambiguous. Head data is presented combinationally.
module byte_fifo
  import axi_bus_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push_ok;
  logic pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  assign push_ok = push && !full;
  assign pop_ok  = pop  && !empty;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their inputs from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read, so
  // stale contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule : byte_fifo

// File: rtl/master_logic.sv
// master_logic: buffers producer bytes and drives them to slave_logic over a
// valid/ready link. Optional MASTER_TXCNT_EN adds a 16-bit handshake counter.
module master_logic
  import axi_bus_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int LVL_W = $clog2(DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  master_logic_if.master    bus
`ifdef MASTER_TXCNT_EN
  ,
  output logic [TXCNT_W-1:0] tx_count
`endif
);

  localparam int CNT_W = cnt_w(DEPTH);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q,   ovf_d;

  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic handshake;
  logic out_free;
  logic load_fifo;
  logic bypass;
  logic push;
  logic drop;
  logic accepted;

  byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (load_fifo),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Queued bytes always win the output register over a new write, which keeps
  // ordering intact; bypass only happens when nothing is waiting.
  assign handshake = (state_q == SEND) && bus.s_ready;
  assign out_free  = (state_q == IDLE) || handshake;
  assign load_fifo = out_free && !fifo_empty;
  assign bypass    = out_free && fifo_empty && wr_en;
  assign push      = wr_en && !bypass && !fifo_full;
  assign drop      = wr_en && !bypass && fifo_full;
  assign accepted  = bypass || push;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    level_d = level_q;
    ovf_d   = ovf_q || drop;

    unique case (state_q)
      IDLE:    if (load_fifo || bypass) state_d = SEND;
      SEND:    if (handshake && !(load_fifo || bypass)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load_fifo)   data_d = fifo_rd_data;
    else if (bypass) data_d = wr_data;

    unique case ({accepted, handshake})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.m_valid = (state_q == SEND);
  assign bus.m_data  = data_q;
  assign full        = fifo_full;
  assign level       = level_q;
  assign overflow    = ovf_q;

`ifdef MASTER_TXCNT_EN
  logic [TXCNT_W-1:0] txcnt_q, txcnt_d;

  always_comb begin
    txcnt_d = txcnt_q;
    if (handshake) txcnt_d = txcnt_q + TXCNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) txcnt_q <= '0;
    else     txcnt_q <= txcnt_d;
  end

  assign tx_count = txcnt_q;
`endif

  // The FIFO count is only consumed via full/empty; keep it visible for debug.
  logic unused_count;
  assign unused_count = ^fifo_count;

endmodule : master_logic

// File: tb/tb_master_logic.sv
// Directed, table-driven bench for master_logic (DEPTH=4, DATA_W=8) with an
// emulated slave that drops ready for one cycle after each accept.
module tb_master_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [2:0] level;
  logic       overflow;
`ifdef MASTER_TXCNT_EN
  logic [15:0] tx_count;
`endif

  int checks = 0;
  int errors = 0;

  master_logic_if #(.DATA_W(8)) bus ();

  master_logic #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .level    (level),
    .overflow (overflow),
    .bus      (bus)
`ifdef MASTER_TXCNT_EN
    ,
    .tx_count (tx_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       s_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_level;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    rst         = r;
    wr_en       = w;
    wr_data     = d;
    bus.s_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    bus.s_ready = 1'b0;

    //            rst wr  data   rdy  val  data   lvl  full ovf
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    // Bypass from idle, handshake next edge, back to idle.
    vecs[1]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 3'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    // Fill with s_ready low: 0x01 bypasses, 0x02..0x05 fill FIFO, 0x06 dropped.
    vecs[3]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 3'd5, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 8'h01, 3'd5, 1'b1, 1'b1};
    // Drain with ready toggling as the slave does.
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 3'd4, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 3'd4, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 3'd3, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 3'd3, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 3'd2, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0, 1'b1};
    // Write 0x07 during a handshake with 0x05 queued: head loads, 0x07 pushed.
    vecs[15] = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 8'h05, 3'd2, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 3'd2, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 3'd1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h07, 3'd1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].wr_en, vecs[i].wr_data, vecs[i].s_ready);
      check($sformatf("v%0d_valid", i), 32'(bus.m_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid || vecs[i].rst)
        check($sformatf("v%0d_data", i), 32'(bus.m_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
    end

`ifdef MASTER_TXCNT_EN
    // Handshakes so far: 0x3C, 0x01..0x05, 0x07.
    check("txcnt_after_table", 32'(tx_count), 32'd7);
`endif

    // Backpressure hold: 0x11 stays put for 5 stalled cycles.
    step(1'b0, 1'b1, 8'h11, 1'b0);
    check("bp_load_valid", 32'(bus.m_valid), 32'd1);
    check("bp_load_data", 32'(bus.m_data), 32'h11);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check($sformatf("bp_hold%0d_valid", c), 32'(bus.m_valid), 32'd1);
      check($sformatf("bp_hold%0d_data", c), 32'(bus.m_data), 32'h11);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("bp_accept_valid", 32'(bus.m_valid), 32'd0);
    check("bp_accept_level", 32'(level), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("bp_idle_valid", 32'(bus.m_valid), 32'd0);
`ifdef MASTER_TXCNT_EN
    check("txcnt_after_bp", 32'(tx_count), 32'd8);
`endif

    // Reset mid-SEND with overflow still sticky from the fill above.
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    check("rs_pre_valid", 32'(bus.m_valid), 32'd1);
    check("rs_pre_data", 32'(bus.m_data), 32'hA5);
    check("rs_pre_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("rs_valid", 32'(bus.m_valid), 32'd0);
    check("rs_data", 32'(bus.m_data), 32'h00);
    check("rs_level", 32'(level), 32'd0);
    check("rs_ovf", 32'(overflow), 32'd0);
    check("rs_full", 32'(full), 32'd0);
`ifdef MASTER_TXCNT_EN
    check("rs_txcnt", 32'(tx_count), 32'd0);
`endif

    // Reset wins over a concurrent write; the byte must be discarded.
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    check("rs_wr_valid", 32'(bus.m_valid), 32'd0);
    check("rs_wr_level", 32'(level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_master_logic
